// File: rtl/m_ext_pkg.sv
// Shared definitions for the M-extension divide unit: operation encoding,
// divider FSM states and the default operand width.
package m_ext_pkg;

    localparam int unsigned XlenDefault = 32;

    // Matches funct3[1:0] of the RV32M divide instructions.
    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StShift = 3'd1,
        StSub   = 3'd2,
        StFix   = 3'd3,
        StDone  = 3'd4
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OpRem) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/divu_core.sv
// Unsigned restoring-division datapath. Holds the accumulator, a shifting copy
// of the dividend, the divisor and the quotient; iteration count lives in the
// controlling sequencer.
module divu_core
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            shift_en,
    input  logic            sub_en,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN:0]   diff;
    logic            fits;

    // Trial subtraction of the divisor from the accumulator.
    always_comb begin
        diff = acc_q - {1'b0, dvs_q};
        fits = acc_q >= {1'b0, dvs_q};
    end

    // Next-state for load, shift and conditional-subtract steps.
    always_comb begin
        acc_d = acc_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        if (load) begin
            acc_d = '0;
            dvd_d = dividend;
            dvs_d = divisor;
            quo_d = '0;
        end else if (shift_en) begin
            // The accumulator MSB is always clear before a shift, so nothing is lost.
            {acc_d, dvd_d} = {acc_q[XLEN-1:0], dvd_q, 1'b0};
            quo_d          = {quo_q[XLEN-2:0], 1'b0};
        end else if (sub_en && fits) begin
            acc_d = diff;
            quo_d = {quo_q[XLEN-1:1], 1'b1};
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
        end else begin
            acc_q <= acc_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = acc_q[XLEN-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Iterative RV32M divider: sign handling, divide-by-zero / overflow shortcuts
// and the SHIFT/SUB/FIX sequencing FSM around the unsigned divu_core.
module div_sequencer
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned    CntW     = $clog2(XLEN);
    localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt   = {1'b1, {(XLEN - 1) {1'b0}}};

    div_state_e      state_q, state_d;
    div_op_e         op_in, op_q;
    logic            neg_quo_q, neg_rem_q;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] result_q;

    logic            in_signed, accept, div_zero, overflow, special;
    logic [XLEN-1:0] abs1, abs2, special_res;
    logic [XLEN-1:0] quotient, remainder, quo_fix, rem_fix, fix_res;
    logic            load, shift_en, sub_en;

    // Request decode: operand magnitudes and the no-iteration special cases.
    always_comb begin
        op_in     = div_op_e'(op);
        in_signed = op_is_signed(op_in);
        accept    = (state_q == StIdle) && start && !kill;
        div_zero  = (rs2 == '0);
        overflow  = in_signed && (rs1 == MinInt) && (rs2 == '1);
        special   = div_zero || overflow;
        abs1      = (in_signed && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2      = (in_signed && rs2[XLEN-1]) ? -rs2 : rs2;
        if (div_zero) begin
            special_res = op_is_rem(op_in) ? rs1 : '1;
        end else begin
            // Signed overflow: quotient is rs1 itself (-2^(XLEN-1)), remainder 0.
            special_res = op_is_rem(op_in) ? '0 : rs1;
        end
    end

    // Sign fix-up of the unsigned core results.
    always_comb begin
        quo_fix = neg_quo_q ? -quotient : quotient;
        rem_fix = neg_rem_q ? -remainder : remainder;
        fix_res = op_is_rem(op_q) ? rem_fix : quo_fix;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; kill aborts from any busy state.
    always_comb begin
        state_d = state_q;
        if (kill && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (accept) state_d = special ? StDone : StShift;
                StShift: state_d = StSub;
                StSub:   state_d = (cnt_q == LastIter) ? StFix : StShift;
                StFix:   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs and datapath controls.
    always_comb begin
        ready    = (state_q == StIdle);
        done     = (state_q == StDone) && !kill;
        load     = accept;
        shift_en = (state_q == StShift) && !kill;
        sub_en   = (state_q == StSub) && !kill;
    end

    // Captured request attributes, iteration counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OpDiv;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                op_q      <= op_in;
                neg_quo_q <= in_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                neg_rem_q <= in_signed && rs1[XLEN-1];
                cnt_q     <= '0;
                if (special) begin
                    result_q <= special_res;
                end
            end
            if (sub_en && (cnt_q != LastIter)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if ((state_q == StFix) && !kill) begin
                result_q <= fix_res;
            end
        end
    end

    assign result = result_q;

    divu_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_en  (shift_en),
        .sub_en    (sub_en),
        .dividend  (abs1),
        .divisor   (abs2),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request; sampled only when ready=1.
REQ-005 SHALL have port op, input, 2, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-006 SHALL have port rs1, input, XLEN, dividend.
REQ-007 SHALL have port rs2, input, XLEN, divisor.
REQ-008 SHALL have port kill, input, 1, pipeline flush; aborts the operation in flight.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse; result valid.
REQ-011 SHALL have port result, output, XLEN, quotient or remainder per op.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT, SUB, FIX, DONE.
REQ-013 SHALL accept a request on the edge where state=IDLE, start=1 and kill=0; it captures op, |rs1|, |rs2| (absolute values only for DIV/REM), the quotient sign (rs1[MSB]^rs2[MSB]) and the remainder sign (rs1[MSB]).
REQ-014 SHALL, on the accepting edge, go from IDLE directly to DONE when rs2==0 or when op=DIV/REM with rs1=-2^(XLEN-1) and rs2=-1; no iterations occur.
REQ-015 SHALL otherwise go IDLE->SHIFT, clear the accumulator (XLEN+1 bits) and quotient, and load a 5-bit iteration counter with 0.
REQ-016 SHALL, in SHIFT, left-shift {accumulator, dividend copy} by 1 and the quotient by 1, then go to SUB.
REQ-017 SHALL, in SUB, subtract the divisor from the accumulator and set quotient[0]=1 when accumulator >= {0,divisor}, and otherwise leave both unchanged.
REQ-018 SHALL, leaving SUB, go to FIX when counter==XLEN-1, and otherwise increment the counter and return to SHIFT.
REQ-019 SHALL, in FIX, negate the quotient when the quotient sign is set and negate the remainder when the remainder sign is set (DIV/REM only), register the selected result, then go to DONE.
REQ-020 SHALL assert done for exactly the one DONE cycle and then go to IDLE.
REQ-021 SHALL hold result from DONE until the next DONE.
REQ-022 SHALL have a normal latency where the accepting edge is followed by 2*XLEN cycles of SHIFT/SUB, 1 FIX cycle and 1 DONE cycle; for XLEN=32, done is high in the 66th cycle after the accepting edge.
REQ-023 SHALL have a special-case latency where done is high in the 1st cycle after the accepting edge.
REQ-024 SHALL produce for divide by zero: DIV/DIVU result all ones; REM/REMU result rs1.
REQ-025 SHALL produce for signed overflow: DIV result -2^(XLEN-1); REM result 0.
REQ-026 SHALL ignore start while ready=0.
REQ-027 SHALL, on kill=1 in any non-IDLE state, go to IDLE on the next edge, suppress done and leave result unchanged.
REQ-028 SHALL give kill priority over start when both are asserted in IDLE, so that no request is accepted.
REQ-029 SHALL give kill priority over done in DONE, so that done is deasserted that cycle.

Reset
REQ-030 SHALL, on rst, set state=IDLE asynchronously, with ready=1, done=0, result=0, and the counter, accumulator and quotient all 0.
REQ-031 SHALL, when rst is asserted mid-operation, abandon the operation with no done pulse.
REQ-032 SHALL not accept the first request until the first rising clk edge after rst is released.

Structure
REQ-033 SHALL take the op encoding enum, the FSM state enum and the XLEN default from shared package m_ext_pkg.
REQ-034 SHALL place the shift/compare/subtract datapath (accumulator, dividend copy, quotient, counter-free) in sub-module divu_core, controlled by load/shift_en/sub_en from div_sequencer.
REQ-035 SHALL keep sign handling, special-case detection and the FSM in div_sequencer.

Verification
REQ-036 SHALL be verified by: DIVU rs1=100, rs2=7 -> result=14, done in the 66th cycle after accept.
REQ-037 SHALL be verified by: REM rs1=-7, rs2=2 -> result=-1; DIV same operands -> result=-3.
REQ-038 SHALL be verified by: DIVU rs1=5, rs2=0 -> 0xFFFFFFFF; REMU rs1=5, rs2=0 -> 5; done 1 cycle after accept.
REQ-039 SHALL be verified by: DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-040 SHALL be verified by: kill at cycle 20 of an operation -> IDLE next cycle, no done, result keeps its previous value; a new start is accepted immediately after.
REQ-041 SHALL be verified by: start pulsed at cycle 10 of a busy operation -> ignored; one done only, with the first operation's result.
